// File: rtl/rw_pkg.sv
// Shared types and constants for the read/write request scheduler.
package rw_pkg;

  localparam int unsigned NREQ          = 2;
  localparam int unsigned IDX_W         = 1;
  localparam int unsigned PAGE_W        = 16;
  localparam int unsigned DATA_W        = 64;
  localparam int unsigned RETRY_W       = 3;
  localparam int unsigned MAX_RETRY_DEF = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RESPOND   = 2'd3
  } state_e;

  // Operands captured from the granted requester
  typedef struct packed {
    logic              wr;
    logic [PAGE_W-1:0] page;
    logic [DATA_W-1:0] wdata;
  } op_t;

endpackage

// File: rtl/rw_sched_if.sv
// Requester-side and rwFSM-side signals of the scheduler, bundled as one interface.
interface rw_sched_if;
  import rw_pkg::*;

  logic [NREQ-1:0]             req;
  logic [NREQ-1:0]             req_wr;
  logic [NREQ-1:0][PAGE_W-1:0] req_page;
  logic [NREQ-1:0][DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]             resp_done;
  logic                        resp_ok;
  logic [DATA_W-1:0]           resp_rdata;
  logic                        busy;
  logic                        start_read;
  logic                        start_write;
  logic [PAGE_W-1:0]           RWmemPage;
  logic [DATA_W-1:0]           RW_data_write;
  logic                        rwFSM_done;
  logic                        read_success;
  logic                        write_success;
  logic [DATA_W-1:0]           RW_data_read;

  // Environment side: requesters plus the rwFSM engine
  modport master (
    output req, req_wr, req_page, req_wdata, rwFSM_done, read_success, write_success, RW_data_read,
    input  resp_done, resp_ok, resp_rdata, busy, start_read, start_write, RWmemPage, RW_data_write
  );

  // Scheduler side
  modport slave (
    input  req, req_wr, req_page, req_wdata, rwFSM_done, read_success, write_success, RW_data_read,
    output resp_done, resp_ok, resp_rdata, busy, start_read, start_write, RWmemPage, RW_data_write
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the last-granted requester loses a tie.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       gnt_o_c
);

  assign gnt_o_c = (req_i == 2'b11) ? ~last_i : req_i[1];

endmodule

// File: rtl/rw_reg.sv
// Generic enable register with asynchronous active-low clear.
module rw_reg #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         rst_L,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L)    q_o <= '0;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/rw_sched.sv
// Round-robin scheduler for two requesters in front of a single rwFSM engine,
// with bounded retry of failed operations.
module rw_sched
  import rw_pkg::*;
#(
  parameter int unsigned MAX_RETRY = MAX_RETRY_DEF
) (
  input logic     clk,
  input logic     rst_L,
  rw_sched_if.slave io
);

  state_e             state_q, state_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   gnt;
  logic               start_rd_q, start_rd_d;
  logic               start_wr_q, start_wr_d;
  logic [NREQ-1:0]    done_q, done_d;
  logic               ok_q, ok_d;
  logic               busy_q, busy_d;
  logic               cap_en;
  logic               success;
  op_t                cap_d, op_q;
  logic [DATA_W-1:0]  rdata_d, rdata_q;

  rr_arb2 u_arb (
    .req_i   (io.req),
    .last_i  (last_q),
    .gnt_o_c (gnt)
  );

  assign cap_d = '{wr: io.req_wr[gnt], page: io.req_page[gnt], wdata: io.req_wdata[gnt]};

  rw_reg #(.W($bits(op_t))) u_op_reg (
    .clk   (clk),
    .rst_L (rst_L),
    .en_i  (cap_en),
    .d_i   (cap_d),
    .q_o   (op_q)
  );

  // Result register is reloaded every cycle so rdata is zero outside RESPOND
  rw_reg #(.W(DATA_W)) u_rdata_reg (
    .clk   (clk),
    .rst_L (rst_L),
    .en_i  (1'b1),
    .d_i   (rdata_d),
    .q_o   (rdata_q)
  );

  always_ff @(posedge clk or negedge rst_L) begin
    if (!rst_L) begin
      state_q    <= IDLE;
      retry_q    <= '0;
      last_q     <= IDX_W'(1);
      idx_q      <= '0;
      start_rd_q <= 1'b0;
      start_wr_q <= 1'b0;
      done_q     <= '0;
      ok_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      retry_q    <= retry_d;
      last_q     <= last_d;
      idx_q      <= idx_d;
      start_rd_q <= start_rd_d;
      start_wr_q <= start_wr_d;
      done_q     <= done_d;
      ok_q       <= ok_d;
      busy_q     <= busy_d;
    end
  end

  // Next state; registered outputs are computed for the state being entered
  always_comb begin
    state_d    = state_q;
    retry_d    = retry_q;
    last_d     = last_q;
    idx_d      = idx_q;
    cap_en     = 1'b0;
    start_rd_d = 1'b0;
    start_wr_d = 1'b0;
    done_d     = '0;
    ok_d       = 1'b0;
    rdata_d    = '0;
    success    = op_q.wr ? io.write_success : io.read_success;

    unique case (state_q)
      IDLE: begin
        if (|io.req) begin
          cap_en     = 1'b1;
          idx_d      = gnt;
          retry_d    = '0;
          start_wr_d = io.req_wr[gnt];
          start_rd_d = ~io.req_wr[gnt];
          state_d    = ISSUE;
        end
      end
      ISSUE: state_d = WAIT_DONE;
      WAIT_DONE: begin
        if (io.rwFSM_done) begin
          if (success) begin
            ok_d          = 1'b1;
            rdata_d       = op_q.wr ? '0 : io.RW_data_read;
            done_d[idx_q] = 1'b1;
            state_d       = RESPOND;
          end else if (retry_q < RETRY_W'(MAX_RETRY)) begin
            retry_d    = (retry_q == '1) ? retry_q : retry_q + RETRY_W'(1);
            start_wr_d = op_q.wr;
            start_rd_d = ~op_q.wr;
            state_d    = ISSUE;
          end else begin
            done_d[idx_q] = 1'b1;
            state_d       = RESPOND;
          end
        end
      end
      RESPOND: begin
        last_d  = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  assign io.start_read    = start_rd_q;
  assign io.start_write   = start_wr_q;
  assign io.resp_done     = done_q;
  assign io.resp_ok       = ok_q;
  assign io.resp_rdata    = rdata_q;
  assign io.busy          = busy_q;
  assign io.RWmemPage     = op_q.page;
  assign io.RW_data_write = op_q.wdata;

endmodule

// File: tb/tb_rw_sched.sv
// Directed bench for rw_sched: scripted rwFSM responder plus a response scoreboard.
module tb_rw_sched;
  import rw_pkg::*;

  logic clk = 1'b0;
  logic rst_L;
  always #5 clk = ~clk;

  rw_sched_if io ();

  rw_sched #(.MAX_RETRY(3)) dut (
    .clk   (clk),
    .rst_L (rst_L),
    .io    (io.slave)
  );

  typedef struct {
    bit          idx;
    bit          wr;
    logic [15:0] page;
    logic [63:0] wdata;
    bit          ok;
    logic [63:0] rdata;
    int          starts;
  } exp_t;

  exp_t        exp_q[$];
  bit          outc_q[$];
  exp_t        mon_e;
  int          vectors = 0;
  int          fails = 0;
  int          start_cnt = 0;
  int          lat = 2;
  int          cnt = 0;
  bit          m_done, m_rs, m_ws, spur, cur_wr, succ_m, done_at_edge;
  logic [63:0] m_rdata;

  assign io.rwFSM_done    = m_done | spur;
  assign io.read_success  = m_rs;
  assign io.write_success = m_ws;
  assign io.RW_data_read  = m_rdata;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic push(input bit idx, input bit wr, input logic [15:0] page, input logic [63:0] wdata,
                      input bit ok, input logic [63:0] rdata, input int starts);
    exp_t e;
    e.idx = idx; e.wr = wr; e.page = page; e.wdata = wdata;
    e.ok = ok; e.rdata = rdata; e.starts = starts;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input bit i, input bit v, input bit wr, input logic [15:0] page,
                         input logic [63:0] wdata);
    io.req[i]       = v;
    io.req_wr[i]    = wr;
    io.req_page[i]  = page;
    io.req_wdata[i] = wdata;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"},        64'(io.busy),          64'd0);
    chk({tag, "_resp_done"},   64'(io.resp_done),     64'd0);
    chk({tag, "_resp_ok"},     64'(io.resp_ok),       64'd0);
    chk({tag, "_resp_rdata"},  io.resp_rdata,         64'd0);
    chk({tag, "_start_read"},  64'(io.start_read),    64'd0);
    chk({tag, "_start_write"}, 64'(io.start_write),   64'd0);
    chk({tag, "_page"},        64'(io.RWmemPage),     64'd0);
    chk({tag, "_wdata"},       io.RW_data_write,      64'd0);
  endtask

  // rwFSM model: done 'lat' cycles after each start, outcome taken from outc_q.
  // A failed attempt raises the success flag of the other operation type.
  always @(negedge clk) begin
    m_done = 1'b0; m_rs = 1'b0; m_ws = 1'b0;
    if (!rst_L) cnt = 0;
    else begin
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          succ_m = (outc_q.size() != 0) ? outc_q.pop_front() : 1'b1;
          m_done = 1'b1;
          m_ws   = succ_m ? cur_wr : ~cur_wr;
          m_rs   = succ_m ? ~cur_wr : cur_wr;
        end
      end
      if (io.start_read || io.start_write) begin
        start_cnt++;
        chk("start_exclusive",   64'(io.start_read & io.start_write), 64'd0);
        chk("start_has_outcome", 64'(outc_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          chk("start_kind",  64'(io.start_write), 64'(exp_q[0].wr));
          chk("start_page",  64'(io.RWmemPage),   64'(exp_q[0].page));
          chk("start_wdata", io.RW_data_write,    exp_q[0].wdata);
        end
        cur_wr = io.start_write;
        cnt    = lat;
      end
    end
  end

  always @(posedge clk) done_at_edge <= io.rwFSM_done;

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (rst_L && io.resp_done != '0) begin
      chk("resp_onehot",     64'($onehot(io.resp_done)), 64'd1);
      chk("resp_after_done", 64'(done_at_edge), 64'd1);
      chk("resp_expected",   64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        chk("resp_idx",    64'(io.resp_done), 64'(2'b01 << mon_e.idx));
        chk("resp_ok",     64'(io.resp_ok),   64'(mon_e.ok));
        chk("resp_rdata",  io.resp_rdata,     mon_e.rdata);
        chk("resp_starts", 64'(start_cnt),    64'(mon_e.starts));
      end
      start_cnt = 0;
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog expired vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_L = 1'b0;
    io.req = '0; io.req_wr = '0; io.req_page = '0; io.req_wdata = '0;
    m_rdata = '0; spur = 1'b0;
    repeat (2) @(negedge clk);
    chk_quiet("reset");
    rst_L = 1'b1;
    @(negedge clk);
    chk_quiet("post_reset");

    // Read, first try
    m_rdata = 64'hDEADBEEF_00000001;
    outc_q.push_back(1'b1);
    push(1'b0, 1'b0, 16'h0012, 64'h0, 1'b1, 64'hDEADBEEF_00000001, 1);
    set_req(1'b0, 1'b1, 1'b0, 16'h0012, 64'h0);
    @(negedge clk);
    chk("t1_start_read",  64'(io.start_read),  64'd1);
    chk("t1_start_write", 64'(io.start_write), 64'd0);
    chk("t1_busy",        64'(io.busy),        64'd1);
    chk("t1_page",        64'(io.RWmemPage),   64'h0012);
    drain(40);
    set_req(1'b0, 1'b0, 1'b0, 16'h0, 64'h0);

    // Write fails twice then succeeds
    m_rdata = 64'h5555_5555_5555_5555;
    outc_q.push_back(1'b0); outc_q.push_back(1'b0); outc_q.push_back(1'b1);
    push(1'b1, 1'b1, 16'hA5A5, 64'h0123_4567_89AB_CDEF, 1'b1, 64'h0, 3);
    set_req(1'b1, 1'b1, 1'b1, 16'hA5A5, 64'h0123_4567_89AB_CDEF);
    @(negedge clk);
    chk("t2_start_write", 64'(io.start_write), 64'd1);
    chk("t2_wdata",       io.RW_data_write,    64'h0123_4567_89AB_CDEF);
    drain(80);
    set_req(1'b1, 1'b0, 1'b0, 16'h0, 64'h0);

    // Write always fails; req dropped mid-transaction; one-cycle rwFSM latency
    lat = 1;
    m_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    repeat (4) outc_q.push_back(1'b0);
    push(1'b0, 1'b1, 16'h00F0, 64'hCAFE_F00D_1234_5678, 1'b0, 64'h0, 4);
    set_req(1'b0, 1'b1, 1'b1, 16'h00F0, 64'hCAFE_F00D_1234_5678);
    @(negedge clk);
    io.req[0] = 1'b0;
    drain(80);
    @(negedge clk);
    chk("t3_idle_busy", 64'(io.busy), 64'd0);

    // Both requesters continuously after reset: order 0,1,0,1
    rst_L = 1'b0;
    @(negedge clk);
    rst_L = 1'b1;
    start_cnt = 0;
    lat = 2;
    m_rdata = 64'h1111_2222_3333_4444;
    repeat (4) outc_q.push_back(1'b1);
    repeat (2) begin
      push(1'b0, 1'b0, 16'h0100, 64'h0, 1'b1, 64'h1111_2222_3333_4444, 1);
      push(1'b1, 1'b1, 16'h0200, 64'hBBBB_0000_BBBB_0000, 1'b1, 64'h0, 1);
    end
    set_req(1'b0, 1'b1, 1'b0, 16'h0100, 64'h0);
    set_req(1'b1, 1'b1, 1'b1, 16'h0200, 64'hBBBB_0000_BBBB_0000);
    drain(200);
    io.req = '0;
    @(negedge clk);

    // Spurious rwFSM_done while idle
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    chk("spur_busy",      64'(io.busy),        64'd0);
    chk("spur_resp_done", 64'(io.resp_done),   64'd0);
    chk("spur_start_rd",  64'(io.start_read),  64'd0);
    chk("spur_start_wr",  64'(io.start_write), 64'd0);
    @(negedge clk);
    chk("spur_busy2",     64'(io.busy),        64'd0);

    // Reset asserted during WAIT_DONE aborts the transaction
    lat = 6;
    outc_q.push_back(1'b1);
    push(1'b0, 1'b0, 16'h0777, 64'h0, 1'b1, 64'h1111_2222_3333_4444, 1);
    set_req(1'b0, 1'b1, 1'b0, 16'h0777, 64'h0);
    @(negedge clk);
    @(negedge clk);
    chk("abort_busy_before", 64'(io.busy), 64'd1);
    #2 rst_L = 1'b0;
    #1 chk_quiet("async_reset");
    io.req[0] = 1'b0;
    exp_q.delete();
    outc_q.delete();
    start_cnt = 0;
    repeat (2) @(negedge clk);
    rst_L = 1'b1;
    repeat (8) @(negedge clk);
    chk_quiet("after_abort");

    // Normal grant after the aborted transaction
    lat = 2;
    outc_q.push_back(1'b1);
    push(1'b1, 1'b1, 16'h0333, 64'h0000_0000_0000_0077, 1'b1, 64'h0, 1);
    set_req(1'b1, 1'b1, 1'b1, 16'h0333, 64'h0000_0000_0000_0077);
    drain(40);
    io.req = '0;

    repeat (3) @(negedge clk);
    chk("final_sb_empty",   64'(exp_q.size()),  64'd0);
    chk("final_outc_empty", 64'(outc_q.size()), 64'd0);
    chk("final_busy",       64'(io.busy),       64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/rw_sched.md
RW_SCHED -- requirements
Module: rw_sched

Interface
REQ-001 Parameter MAX_RETRY, default 3: retries after the first failed attempt, legal range 0..7.
REQ-002 Parameter NREQ, fixed at 2: number of requesters.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst_L  in  1  reset, asynchronous, active-low.
REQ-005 req  in  NREQ  per-requester request level; held high until the matching resp_done.
REQ-006 req_wr  in  NREQ  1 = write, 0 = read; valid while req is high.
REQ-007 req_page  in  NREQ x 16  memory page per requester.
REQ-008 req_wdata  in  NREQ x 64  write data per requester.
REQ-009 resp_done  out  NREQ  one-cycle completion pulse per requester.
REQ-010 resp_ok  out  1  transaction success; valid with any resp_done.
REQ-011 resp_rdata  out  64  read data; valid with resp_done for a successful read, else 0.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 start_read, start_write  out  1 each  one-cycle start pulses to rwFSM.
REQ-014 RWmemPage  out  16; RW_data_write  out  64  operands to rwFSM.
REQ-015 rwFSM_done, read_success, write_success  in  1 each; RW_data_read  in  64  results from rwFSM.

Function
REQ-016 The state machine SHALL have four states: IDLE, ISSUE, WAIT_DONE, RESPOND.
REQ-017 IDLE: if any req bit is high, grant one round-robin, capture the winner's index, wr, page and wdata into registers, clear retry_cnt, and go to ISSUE.
REQ-018 Round-robin: the last-granted requester has lowest priority; after reset requester 0 has priority; with only one requester asserting, it wins immediately.
REQ-019 ISSUE (exactly one cycle): assert start_write if the captured wr = 1, else start_read; never both; then go to WAIT_DONE.
REQ-020 RWmemPage and RW_data_write SHALL be driven from the captured registers, stable from ISSUE until the transaction leaves WAIT_DONE for RESPOND.
REQ-021 WAIT_DONE: hold until rwFSM_done; success = read_success for a read, write_success for a write.
REQ-022 On done with success: latch RW_data_read (reads only) into resp_rdata, set ok = 1, and go to RESPOND.
REQ-023 On done with failure:
  - retry_cnt < MAX_RETRY: increment retry_cnt and go to ISSUE (re-issue the same operands);
  - otherwise: set ok = 0 and go to RESPOND.
REQ-024 RESPOND (one cycle): pulse resp_done[granted index], drive resp_ok and resp_rdata, record the granted index as last-granted, and return to IDLE.
REQ-025 The earliest new grant is the cycle after RESPOND, so a requester that keeps req high after resp_done is serviced again only after other pending requesters.
REQ-026 Latency, first-try success: start pulse 1 cycle after grant; resp_done 1 cycle after rwFSM_done.
REQ-027 A req deasserting mid-transaction SHALL be ignored; the transaction completes and resp_done still pulses.
REQ-028 retry_cnt is 3 bits and SHALL saturate, never wrap.
REQ-029 rwFSM_done while in IDLE, ISSUE or RESPOND SHALL be ignored.

Reset
REQ-030 Reset state and output values:
  - state = IDLE; start_read, start_write, resp_done, resp_ok, busy = 0;
  - resp_rdata, RWmemPage, RW_data_write = 0;
  - retry_cnt = 0; last-granted = 1, so requester 0 has priority.
REQ-031 Reset asserted mid-transaction SHALL abort immediately with no resp_done and no further start pulse.

Structure
REQ-032 The state enum and MAX_RETRY default SHALL live in shared package rw_pkg.
REQ-033 The round-robin grant logic SHALL be the sub-module rr_arb2: inputs req[1:0] and last; output gnt index.
REQ-034 Operand and result holding SHALL use the codebase's existing register module.

Verification
REQ-035 Read, first try: req[0]=1, wr=0, page 16'h0012; model returns read_success with data 64'hDEADBEEF_00000001 -> single start_read; resp_done[0]; resp_ok=1; resp_rdata=64'hDEADBEEF_00000001.
REQ-036 Write fails twice then succeeds (MAX_RETRY=3) -> 3 start_write pulses, identical page/data on each; resp_ok=1.
REQ-037 Write always fails -> exactly 4 start_write pulses; resp_ok=0; resp_rdata=0.
REQ-038 Both requesters assert continuously after reset -> grant order 0,1,0,1; resp_done never to both in one cycle.
REQ-039 rst_L low during WAIT_DONE -> busy=0 and all outputs 0 asynchronously; no resp_done; the next req is granted normally.
REQ-040 Spurious rwFSM_done in IDLE -> no state change, no resp_done.
